// File: rtl/rv32i_alu_issue_if.sv
// Handshake bundle between the decode/issue stage and its neighbours:
// the instruction/operand side (in_*) and the ALU op/operand side (out_*).
interface rv32i_alu_issue_if #(
  parameter int RD_W = 5,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic [31:0]     in_rs1_val;
  logic [31:0]     in_rs2_val;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_op;
  logic [31:0]     out_a;
  logic [31:0]     out_b;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, in_rs1_val, in_rs2_val, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, out_rd, out_illegal
  );
endinterface

// File: rtl/rv32i_alu_issue.sv
// RV32I decode/issue stage: decodes one instruction per transfer into an ALU op and operands.
// Define ALU_ISSUE_SKID_EN for a one-entry skid buffer with a registered in_ready.
module rv32i_alu_issue #(
  parameter int RD_W = 5,
  parameter int OP_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  rv32i_alu_issue_if.slave       bus
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_e;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRA = OP_W'(13);
  localparam logic [6:0]      F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [RD_W-1:0] rd;
    logic            illegal;
  } issue_t;

  issue_t      dec;
  issue_t      out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        out_free;
  logic        in_fire;
  logic        dec_ill;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_u, shamt;

  assign f3    = bus.in_inst[14:12];
  assign f7    = bus.in_inst[31:25];
  assign imm_i = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
  assign imm_s = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
  assign imm_u = {bus.in_inst[31:12], 12'b0};
  assign shamt = {27'b0, bus.in_inst[24:20]};

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec         = '0;
    dec.op      = OP_ADD;
    dec.rd      = bus.in_inst[11:7];
    dec_ill     = 1'b0;
    case (bus.in_inst[6:0])
      OPC_OP: begin
        dec.a  = bus.in_rs1_val;
        dec.b  = bus.in_rs2_val;
        dec.op = OP_W'({bus.in_inst[30], f3});
        if (!((f7 == 7'b0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)))))
          dec_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a  = bus.in_rs1_val;
        dec.b  = imm_i;
        dec.op = OP_W'({1'b0, f3});
        if (f3 == 3'b001) begin
          dec.b = shamt;
          if (f7 != 7'b0) dec_ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.b = shamt;
          if (f7 == 7'b0)         dec.op  = OP_SRL;
          else if (f7 == F7_ALT)  dec.op  = OP_SRA;
          else                    dec_ill = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.b = imm_u;
      end
      OPC_AUIPC: begin
        dec.a = bus.in_pc;
        dec.b = imm_u;
      end
      OPC_LOAD: begin
        dec.a = bus.in_rs1_val;
        dec.b = imm_i;
      end
      OPC_STORE: begin
        dec.a  = bus.in_rs1_val;
        dec.b  = imm_s;
        dec.rd = '0;
      end
      default: dec_ill = 1'b1;
    endcase
    // Any undecodable encoding issues as a harmless ADD 0,0 with no destination.
    if (dec_ill) begin
      dec         = '0;
      dec.op      = OP_ADD;
      dec.illegal = 1'b1;
    end
  end

  assign out_free = !out_valid_q || bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;

  assign in_fire = bus.in_valid && in_ready_q;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low while the skid holds data, so nothing new arrives here.
      if (out_free) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready = in_ready_q;
`else
  assign in_fire = bus.in_valid && out_free;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready = out_free;
`endif

  // NOTE: sequential state uses non-blocking assignments only; the payload is reset too
  // because the outputs must read as zero after reset, not just the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_q.op;
  assign bus.out_a       = out_q.a;
  assign bus.out_b       = out_q.b;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Directed-vector bench for rv32i_alu_issue: decode results, backpressure, flush and async reset.
module tb_rv32i_alu_issue;
  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  rv32i_alu_issue_if bus ();

  rv32i_alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic ill);
    check({tag, ".valid"},   32'(bus.out_valid),   32'(valid));
    check({tag, ".op"},      32'(bus.out_op),      32'(op));
    check({tag, ".a"},       bus.out_a,            a);
    check({tag, ".b"},       bus.out_b,            b);
    check({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
    check({tag, ".illegal"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  // Present one instruction and hold it until accepted (bounded), then withdraw.
  task automatic send(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    bit acc;
    acc            = 1'b0;
    bus.in_inst    = inst;
    bus.in_pc      = pc;
    bus.in_rs1_val = rs1;
    bus.in_rs2_val = rs2;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 8 && !acc; i++) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check({tag, ".accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit acc;
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_inst    = '0;
    bus.in_pc      = '0;
    bus.in_rs1_val = '0;
    bus.in_rs2_val = '0;
    bus.out_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    idle(1);

    // Register-register, immediate, upper-immediate, memory and illegal decodes.
    send("add", 32'h002081B3, 32'h0, 32'd5, 32'd7);
    check_out("add", 1'b1, 5'h00, 32'd5, 32'd7, 5'd3, 1'b0);
    send("sub", 32'h402081B3, 32'h0, 32'd5, 32'd7);
    check_out("sub", 1'b1, 5'h08, 32'd5, 32'd7, 5'd3, 1'b0);
    send("sltu", 32'h0020B1B3, 32'h0, 32'd1, 32'd2);
    check_out("sltu", 1'b1, 5'h03, 32'd1, 32'd2, 5'd3, 1'b0);
    send("srai", 32'h40435293, 32'h0, 32'h80000000, 32'h55);
    check_out("srai", 1'b1, 5'h0D, 32'h80000000, 32'd4, 5'd5, 1'b0);
    send("addi", 32'hFFF00513, 32'h0, 32'd9, 32'h77);
    check_out("addi", 1'b1, 5'h00, 32'd9, 32'hFFFFFFFF, 5'd10, 1'b0);
    send("lui", 32'h123450B7, 32'h0, 32'hDEAD, 32'hBEEF);
    check_out("lui", 1'b1, 5'h00, 32'h0, 32'h12345000, 5'd1, 1'b0);
    send("auipc", 32'h80000217, 32'h100, 32'hDEAD, 32'hBEEF);
    check_out("auipc", 1'b1, 5'h00, 32'h100, 32'h80000000, 5'd4, 1'b0);
    send("sw", 32'hFE20AE23, 32'h0, 32'h1000, 32'h22);
    check_out("sw", 1'b1, 5'h00, 32'h1000, 32'hFFFFFFFC, 5'd0, 1'b0);
    send("jal", 32'h0000006F, 32'h40, 32'hDEAD, 32'hBEEF);
    check_out("jal", 1'b1, 5'h00, 32'h0, 32'h0, 5'd0, 1'b1);
    send("slli_bad", 32'h40109093, 32'h0, 32'd3, 32'd3);
    check("slli_bad.illegal", 32'(bus.out_illegal), 32'd1);
    idle(1);
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: output held for three cycles while the next instruction waits.
    bus.out_ready = 1'b0;
    send("bp_or", 32'h0020E1B3, 32'h0, 32'd1, 32'd2);
    check_out("bp_or", 1'b1, 5'h06, 32'd1, 32'd2, 5'd3, 1'b0);
    bus.in_inst    = 32'h0020F1B3;
    bus.in_rs1_val = 32'd3;
    bus.in_rs2_val = 32'd4;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
`ifdef ALU_ISSUE_SKID_EN
      check("bp.in_ready", 32'(bus.in_ready), (k == 0) ? 32'd1 : 32'd0);
`else
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
`endif
      acc = bus.in_ready && bus.in_valid;
      @(posedge clk);
      #1;
      if (acc) bus.in_valid = 1'b0;
      check_out("bp.hold", 1'b1, 5'h06, 32'd1, 32'd2, 5'd3, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    acc = bus.in_ready && bus.in_valid;
    @(posedge clk);
    #1;
    if (acc) bus.in_valid = 1'b0;
    check("bp.in_valid_released", 32'(bus.in_valid), 32'd0);
    check_out("bp_and", 1'b1, 5'h07, 32'd3, 32'd4, 5'd3, 1'b0);
    check("bp.in_ready_after", 32'(bus.in_ready), 32'd1);
    idle(1);
    check("bp.no_dup", 32'(bus.out_valid), 32'd0);

    // Flush with a held output and a coincident input transfer.
    bus.out_ready = 1'b0;
    send("fl_c", 32'h002081B3, 32'h0, 32'd10, 32'd20);
    check_out("fl_c", 1'b1, 5'h00, 32'd10, 32'd20, 5'd3, 1'b0);
    bus.in_inst    = 32'h402081B3;
    bus.in_rs1_val = 32'd30;
    bus.in_rs2_val = 32'd40;
    bus.in_valid   = 1'b1;
    flush          = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush.valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("flush.quiet", 32'(bus.out_valid), 32'd0);
    end
    send("fl_e", 32'h0020E1B3, 32'h0, 32'h0F0, 32'h00F);
    check_out("fl_e", 1'b1, 5'h06, 32'h0F0, 32'h00F, 5'd3, 1'b0);
    idle(1);

    // Asynchronous reset while an op is being held on the output.
    bus.out_ready = 1'b0;
    send("rst_f", 32'h123450B7, 32'h0, 32'h0, 32'h0);
    check("rst_f.valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    send("post_rst", 32'h002081B3, 32'h0, 32'd100, 32'd23);
    check_out("post_rst", 1'b1, 5'h00, 32'd100, 32'd23, 5'd3, 1'b0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
